// File: rtl/q_dot3_unit.sv
// Sequential 3-component Q16.48 dot product: one saturating multiplier shared over three
// cycles, accumulated through a saturating adder, with valid/ready on both sides.
module q_dot3_unit #(
  parameter int unsigned W    = 64,
  parameter int unsigned FRAC = 48
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] ax,
  input  logic [W-1:0] ay,
  input  logic [W-1:0] az,
  input  logic [W-1:0] bx,
  input  logic [W-1:0] by,
  input  logic [W-1:0] bz,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_dot,
  output logic         out_sat
);

  localparam int unsigned PW = 2 * W;
  localparam logic [W-1:0] SatMax = {1'b0, {(W - 1){1'b1}}};
  localparam logic [W-1:0] SatMin = {1'b1, {(W - 1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StMulX, StMulY, StMulZ, StDone} state_e;

  state_e state_q, state_d;
  logic [2:0][W-1:0] a_q, a_d, b_q, b_d;
  logic [W-1:0] acc_q, acc_d;
  logic sat_q, sat_d;
  logic out_valid_q, out_valid_d;
  logic [W-1:0] out_dot_q, out_dot_d;
  logic out_sat_q, out_sat_d;

  logic [W-1:0]      mul_a, mul_b, mul_p;
  logic [PW-1:0]     prod;
  logic [W-FRAC:0]   prod_hi;
  logic              mul_fits;
  logic [W:0]        sum_ext;
  logic              add_ovf;
  logic [W-1:0]      add_res;
  logic              unused_frac;

  // Operand pair for the component being multiplied this cycle.
  always_comb begin
    mul_a = a_q[0];
    mul_b = b_q[0];
    case (state_q)
      StMulY: begin
        mul_a = a_q[1];
        mul_b = b_q[1];
      end
      StMulZ: begin
        mul_a = a_q[2];
        mul_b = b_q[2];
      end
      default: ;
    endcase
  end

  // Full signed product, rescaled by FRAC; clamps when it does not fit in Q16.48.
  always_comb begin
    prod     = {{W{mul_a[W-1]}}, mul_a} * {{W{mul_b[W-1]}}, mul_b};
    prod_hi  = prod[PW-1:W+FRAC-1];
    mul_fits = (&prod_hi) | ~(|prod_hi);
    mul_p    = mul_fits ? prod[W+FRAC-1:FRAC] : (prod[PW-1] ? SatMin : SatMax);
  end

  assign unused_frac = ^prod[FRAC-1:0];

  // One extra bit of headroom: the top two bits disagree exactly on signed overflow.
  always_comb begin
    sum_ext = {acc_q[W-1], acc_q} + {mul_p[W-1], mul_p};
    add_ovf = sum_ext[W] ^ sum_ext[W-1];
    add_res = add_ovf ? (sum_ext[W] ? SatMin : SatMax) : sum_ext[W-1:0];
  end

  assign in_ready  = reset && (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign out_dot   = out_dot_q;
  assign out_sat   = out_sat_q;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_dot_d   = out_dot_q;
    out_sat_d   = out_sat_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = {az, ay, ax};
          b_d     = {bz, by, bx};
          acc_d   = '0;
          sat_d   = 1'b0;
          state_d = StMulX;
        end
      end
      StMulX, StMulY: begin
        acc_d   = add_res;
        sat_d   = sat_q | add_ovf;
        state_d = (state_q == StMulX) ? StMulY : StMulZ;
      end
      StMulZ: begin
        acc_d       = add_res;
        sat_d       = sat_q | add_ovf;
        out_dot_d   = add_res;
        out_sat_d   = sat_q | add_ovf;
        out_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_dot_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_dot_q   <= out_dot_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_q_dot3_unit.sv
// Directed bench for q_dot3_unit: reset, arithmetic, saturation, backpressure, mid-op reset,
// and back-to-back issue timing.
module tb_q_dot3_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] ax, ay, az, bx, by, bz;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_dot;
  logic        out_sat;

  int total = 0;
  int bad = 0;

  localparam logic [63:0] Half   = 64'h0000_8000_0000_0000;
  localparam logic [63:0] NegOne5 = 64'hFFFE_8000_0000_0000;
  localparam logic [63:0] PosSat = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NegSat = 64'h8000_0000_0000_0000;

  q_dot3_unit #(.W(64), .FRAC(48)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ax       (ax),
    .ay       (ay),
    .az       (az),
    .bx       (bx),
    .by       (by),
    .bz       (bz),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_dot  (out_dot),
    .out_sat  (out_sat)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] fx(input longint n);
    return 64'(n <<< 48);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0] a0, a1, a2, b0, b1, b2);
    ax = a0; ay = a1; az = a2;
    bx = b0; by = b1; bz = b2;
  endtask

  // Leaves the bench 1ns after the acceptance edge.
  task automatic accept(output bit ok);
    ok = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      else step();
    end
    if (ok) step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    load('0, '0, '0, '0, '0, '0);
    repeat (2) step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", out_valid); end
    total++; if (out_dot !== 64'h0) begin bad++; $display("FAIL rst_dot got %h want 0", out_dot); end
    total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL rst_sat got %b want 0", out_sat); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_low got %b want 0", in_ready); end
    reset = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_idle got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    bit ok;
    int lat;
    load(fx(1), fx(2), fx(3), fx(4), fx(5), fx(6));
    accept(ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_accept got timeout want accept"); end
    // Scramble inputs after acceptance: operands must already be registered.
    load(fx(-7), fx(9), fx(11), fx(100), fx(-3), fx(2));
    wait_valid(lat);
    // out_valid is registered at edge T+3 and seen downstream at edge T+4.
    total++; if (lat !== 3) begin bad++; $display("FAIL basic_latency got %0d want 3", lat); end
    total++; if (out_dot !== 64'h0020_0000_0000_0000) begin
      bad++; $display("FAIL basic_dot got %h want 0020000000000000", out_dot); end
    total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL basic_sat got %b want 0", out_sat); end
    consume();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drop got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got %b want 1", in_ready); end
  endtask

  task automatic test_signed();
    bit ok;
    int lat;
    load(NegOne5, fx(0), Half, fx(2), fx(7), fx(-4));
    accept(ok);
    wait_valid(lat);
    total++; if (!ok || lat !== 3) begin bad++; $display("FAIL signed_timing got ok=%b lat=%0d want ok=1 lat=3", ok, lat); end
    total++; if (out_dot !== 64'hFFFB_0000_0000_0000) begin
      bad++; $display("FAIL signed_dot got %h want fffb000000000000", out_dot); end
    total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL signed_sat got %b want 0", out_sat); end
    consume();
  endtask

  task automatic test_sat_pos();
    bit ok;
    int lat;
    load(fx(30000), fx(30000), fx(30000), fx(1), fx(1), fx(1));
    accept(ok);
    wait_valid(lat);
    total++; if (!ok || lat !== 3) begin bad++; $display("FAIL satpos_timing got ok=%b lat=%0d want ok=1 lat=3", ok, lat); end
    total++; if (out_dot !== PosSat) begin bad++; $display("FAIL satpos_dot got %h want %h", out_dot, PosSat); end
    total++; if (out_sat !== 1'b1) begin bad++; $display("FAIL satpos_sat got %b want 1", out_sat); end
    consume();
  endtask

  task automatic test_sat_neg();
    bit ok;
    int lat;
    load(fx(30000), fx(30000), fx(30000), fx(-1), fx(-1), fx(-1));
    accept(ok);
    wait_valid(lat);
    total++; if (!ok || lat !== 3) begin bad++; $display("FAIL satneg_timing got ok=%b lat=%0d want ok=1 lat=3", ok, lat); end
    total++; if (out_dot !== NegSat) begin bad++; $display("FAIL satneg_dot got %h want %h", out_dot, NegSat); end
    total++; if (out_sat !== 1'b1) begin bad++; $display("FAIL satneg_sat got %b want 1", out_sat); end
    consume();
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    int hold_bad;
    load(fx(1), fx(2), fx(3), fx(4), fx(5), fx(6));
    accept(ok);
    wait_valid(lat);
    total++; if (!ok || lat !== 3) begin bad++; $display("FAIL bp_timing got ok=%b lat=%0d want ok=1 lat=3", ok, lat); end
    hold_bad = 0;
    for (int i = 0; i < 10; i++) begin
      load({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
           {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      in_valid = i[0];
      step();
      if (out_valid !== 1'b1 || out_dot !== 64'h0020_0000_0000_0000 || out_sat !== 1'b0 ||
          in_ready !== 1'b0) begin
        hold_bad++;
        $display("FAIL bp_hold cycle %0d got v=%b dot=%h sat=%b rdy=%b want v=1 dot=0020000000000000 sat=0 rdy=0",
                 i, out_valid, out_dot, out_sat, in_ready);
      end
    end
    total++; if (hold_bad != 0) bad++;
    in_valid = 1'b0;
    load(fx(1), fx(1), fx(1), fx(1), fx(1), fx(1));
    consume();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready got %b want 1", in_ready); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_single got %b want 0", out_valid); end
    accept(ok);
    wait_valid(lat);
    total++; if (!ok || lat !== 3) begin bad++; $display("FAIL bp_next_timing got ok=%b lat=%0d want ok=1 lat=3", ok, lat); end
    total++; if (out_dot !== 64'h0003_0000_0000_0000) begin
      bad++; $display("FAIL bp_next_dot got %h want 0003000000000000", out_dot); end
    consume();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int lat;
    int seen;
    load(fx(1), fx(2), fx(3), fx(4), fx(5), fx(6));
    accept(ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_accept got timeout want accept"); end
    step();  // now in MUL_Y
    reset = 1'b0;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got %b want 0", out_valid); end
    total++; if (out_dot !== 64'h0) begin bad++; $display("FAIL rmid_dot got %h want 0", out_dot); end
    reset = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_idle got %b want 1", in_ready); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rmid_nopulse got %0d want 0", seen); end
    load(fx(1), fx(1), fx(1), fx(1), fx(1), fx(1));
    accept(ok);
    wait_valid(lat);
    total++; if (!ok || lat !== 3) begin bad++; $display("FAIL rmid_timing got ok=%b lat=%0d want ok=1 lat=3", ok, lat); end
    total++; if (out_dot !== 64'h0003_0000_0000_0000) begin
      bad++; $display("FAIL rmid_dot2 got %h want 0003000000000000", out_dot); end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [63:0] sa [3][6];
    logic [63:0] want [3];
    logic [63:0] res [3];
    int acc_t [3];
    int idx, nres;
    bit rdy;
    sa[0] = '{fx(1), fx(2), fx(3), fx(4), fx(5), fx(6)};
    sa[1] = '{fx(1), fx(1), fx(1), fx(1), fx(1), fx(1)};
    sa[2] = '{NegOne5, fx(0), Half, fx(2), fx(7), fx(-4)};
    want = '{64'h0020_0000_0000_0000, 64'h0003_0000_0000_0000, 64'hFFFB_0000_0000_0000};
    res = '{64'h0, 64'h0, 64'h0};
    acc_t = '{0, 0, 0};
    idx = 0;
    nres = 0;
    load(sa[0][0], sa[0][1], sa[0][2], sa[0][3], sa[0][4], sa[0][5]);
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 60 && nres < 3; c++) begin
      rdy = in_ready && in_valid;
      step();
      if (rdy) begin
        acc_t[idx] = c;
        idx++;
        if (idx < 3) load(sa[idx][0], sa[idx][1], sa[idx][2], sa[idx][3], sa[idx][4], sa[idx][5]);
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        if (nres < 3) res[nres] = out_dot;
        nres++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    total++; if (nres != 3) begin bad++; $display("FAIL b2b_count got %0d want 3", nres); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (res[i] !== want[i]) begin
        bad++; $display("FAIL b2b_result%0d got %h want %h", i, res[i], want[i]);
      end
    end
    for (int i = 1; i < 3; i++) begin
      total++;
      if (acc_t[i] - acc_t[i-1] != 5) begin
        bad++; $display("FAIL b2b_interval%0d got %0d want 5", i, acc_t[i] - acc_t[i-1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_sat_pos();
    test_sat_neg();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
